framebuffer_unit: RTL

FRAMEBUFFER_UNIT -- requirements
Module: framebuffer_unit

---
 rtl/framebuffer_unit_if.sv | 39 +++
 rtl/framebuffer_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_unit_if.sv
// -----------------------------------------------------------------------------
// framebuffer_unit_if
//   Draw-side bus of the double-buffered framebuffer: a valid/ready write
//   channel with per-channel mask, and a fixed-latency read of the back bank.
//
//   master : drawing engine (drives wr_valid/wr_addr/wr_data/wr_mask,
//            rd_en/rd_addr; receives wr_ready, rd_data, rd_valid)
//   slave  : framebuffer_unit
//
//   Channel c of any data word lives at bits [c*WORD_W +: WORD_W].
// -----------------------------------------------------------------------------
interface framebuffer_unit_if #(
   parameter int CHANNELS = 3,
   parameter int WORD_W   = 256,
   parameter int ADDR_W   = 10
);
   localparam int DATA_W = CHANNELS * WORD_W;

   logic                wr_valid;
   logic                wr_ready;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic [CHANNELS-1:0] wr_mask;

   logic                rd_en;
   logic [ADDR_W-1:0]   rd_addr;
   logic [DATA_W-1:0]   rd_data;
   logic                rd_valid;

   modport master (
      output wr_valid, wr_addr, wr_data, wr_mask, rd_en, rd_addr,
      input  wr_ready, rd_data, rd_valid
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, wr_mask, rd_en, rd_addr,
      output wr_ready, rd_data, rd_valid
   );
endinterface

// File: rtl/framebuffer_unit.sv
// -----------------------------------------------------------------------------
// framebuffer_unit
//   Double-buffered framebuffer. Two banks, each holding CHANNELS arrays of
//   DEPTH x WORD_W. The drawing engine writes/reads the back bank
//   (!front_sel); the display scans the front bank. A queued swap is taken
//   at the next frame_end when no clear is running. A clear fills every
//   word of the back bank with one value, one word per cycle.
//
//   Ports
//     clock        : single rising-edge clock
//     clr_n        : asynchronous active-low reset
//     draw         : draw-side write channel + back-bank read (interface)
//     scan_en/addr : scan-out read request of the front bank
//     scan_data/valid : scan-out result, one cycle after the request
//     frame_end    : one-cycle pulse at end of a displayed frame
//     swap_req     : one-cycle request to exchange front/back banks
//     swap_pending : a swap is queued
//     front_sel    : index of the displayed bank
//     clear_start  : start filling the back bank with clear_value
//     clear_value  : fill data, captured when clear_start is accepted
//     busy         : fill in progress (exactly DEPTH cycles)
// -----------------------------------------------------------------------------
module framebuffer_unit #(
   parameter  int CHANNELS = 3,
   parameter  int WORD_W   = 256,
   parameter  int DEPTH    = 1024,
   localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int DATA_W   = CHANNELS * WORD_W
) (
   input  logic                clock,
   input  logic                clr_n,

   framebuffer_unit_if.slave   draw,

   input  logic                scan_en,
   input  logic [ADDR_W-1:0]   scan_addr,
   output logic [DATA_W-1:0]   scan_data,
   output logic                scan_valid,

   input  logic                frame_end,
   input  logic                swap_req,
   output logic                swap_pending,
   output logic                front_sel,

   input  logic                clear_start,
   input  logic [DATA_W-1:0]   clear_value,
   output logic                busy
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   // Address DEPTH-1 is the last word of a fill; wider compare constant keeps
   // the range check correct when DEPTH is not a power of two.
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]   fill_q, fill_d;
   logic                front_q, front_d;
   logic                pend_q, pend_d;

   logic                rd_valid_q;
   logic [DATA_W-1:0]   rd_data_q;
   logic                scan_valid_q;
   logic [DATA_W-1:0]   scan_data_q;

   logic [WORD_W-1:0]   mem_q [2][CHANNELS][DEPTH];

   logic                back_bank;
   logic                wr_in_range;
   logic                rd_in_range;
   logic                scan_in_range;
   logic                draw_we;
   logic                clr_we;
   logic                do_swap;
   logic [DATA_W-1:0]   rd_word;
   logic [DATA_W-1:0]   scan_word;

   assign back_bank     = ~front_q;
   assign wr_in_range   = ({1'b0, draw.wr_addr} < DEPTH_EXT);
   assign rd_in_range   = ({1'b0, draw.rd_addr} < DEPTH_EXT);
   assign scan_in_range = ({1'b0, scan_addr}    < DEPTH_EXT);

   // ---------------------------------------------------------------------------
   // Fill FSM: next state and memory write enables
   // ---------------------------------------------------------------------------
   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fill_d  = fill_q;
      draw_we = 1'b0;
      clr_we  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // clr_n gating keeps a write presented during reset out of memory.
            draw_we = draw.wr_valid && wr_in_range && clr_n;
            if (clear_start) begin
               fill_d  = clear_value;
               cnt_d   = '0;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            // clear_start is ignored here; draw writes stall on wr_ready=0.
            clr_we = 1'b1;
            if (cnt_q == LAST_ADDR) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Swap control: sticky request, taken at frame_end only while idle
   // ---------------------------------------------------------------------------
   always_comb begin
      front_d = front_q;
      pend_d  = pend_q;
      do_swap = frame_end && pend_q && (state_q == ST_IDLE);

      if (do_swap) begin
         front_d = ~front_q;
         pend_d  = 1'b0;
      end else if (swap_req) begin
         pend_d = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Read muxes: bank chosen from the current front_sel, i.e. at request time
   // ---------------------------------------------------------------------------
   always_comb begin
      rd_word   = '0;
      scan_word = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (rd_in_range)
            rd_word[c*WORD_W +: WORD_W] = mem_q[back_bank][c][draw.rd_addr];
         if (scan_in_range)
            scan_word[c*WORD_W +: WORD_W] = mem_q[front_q][c][scan_addr];
      end
   end

   // ---------------------------------------------------------------------------
   // Control registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would make results depend on block order.
   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         fill_q       <= '0;
         front_q      <= 1'b0;
         pend_q       <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= '0;
         scan_valid_q <= 1'b0;
         scan_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         fill_q       <= fill_d;
         front_q      <= front_d;
         pend_q       <= pend_d;
         rd_valid_q   <= draw.rd_en;
         scan_valid_q <= scan_en;
         if (draw.rd_en) rd_data_q   <= rd_word;
         if (scan_en)    scan_data_q <= scan_word;
      end
   end

   // ---------------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------------
   // NOTE: the arrays have no reset so they map onto RAM macros; contents after
   // power-up are undefined and an aborted fill leaves the rest untouched.
   always_ff @(posedge clock) begin
      for (int c = 0; c < CHANNELS; c++) begin
         if (clr_we)
            mem_q[back_bank][c][cnt_q] <= fill_q[c*WORD_W +: WORD_W];
         else if (draw_we && draw.wr_mask[c])
            mem_q[back_bank][c][draw.wr_addr] <= draw.wr_data[c*WORD_W +: WORD_W];
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign draw.wr_ready = (state_q == ST_IDLE);
   assign busy          = (state_q == ST_CLEAR);
   assign draw.rd_valid = rd_valid_q;
   assign draw.rd_data  = rd_data_q;
   assign scan_valid    = scan_valid_q;
   assign scan_data     = scan_data_q;
   assign swap_pending  = pend_q;
   assign front_sel     = front_q;

endmodule
